// File: rtl/fifo_pop_stream_pkg.sv
// Shared types and constants for the FIFO pop-side stream stage.
package fifo_pop_stream_pkg;
   localparam int WORD_W    = 8;
   localparam int BUF_DEPTH = 3;
   localparam int LVL_W     = 2;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [LVL_W-1:0]  lvl_t;

   // Circular pointer advance over BUF_DEPTH entries.
   function automatic lvl_t ptr_inc(input lvl_t p);
      return (p == lvl_t'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
endpackage

// File: rtl/fifo_pop_stream_buf3.sv
// 3-entry circular output buffer; head entry is presented combinationally from registers.
module stream_buf3
   import fifo_pop_stream_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] head_data,
   output logic [LVL_W-1:0] level
);
   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] mem_d [BUF_DEPTH];
   lvl_t wr_ptr_q, wr_ptr_d;
   lvl_t rd_ptr_q, rd_ptr_d;
   lvl_t level_q, level_d;
   logic wr, rd;

   always_comb begin
      wr       = wr_en & ~clr;
      rd       = rd_en & (level_q != '0) & ~clr;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (rd) rd_ptr_d = ptr_inc(rd_ptr_q);
         // Write and read together leave the count unchanged at any level.
         level_d = level_q + lvl_t'(wr) - lvl_t'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;
endmodule

// File: rtl/fifo_pop_stream.sv
// Pops a registered-output FIFO under a 3-word credit and re-presents the words as a
// valid/ready stream; fifo_pop never depends on m_ready.
module fifo_pop_stream
   import fifo_pop_stream_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   input  logic             fifo_push,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_pop,
   input  logic             flush,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       level
);
   localparam logic [LVL_W:0] CREDITS = BUF_DEPTH[LVL_W:0];

   logic             inflight_q, inflight_d;
   logic             pop_acc, fire;
   logic [LVL_W:0]   credit_used;
   logic [LVL_W-1:0] buf_level;
   logic [WIDTH-1:0] buf_head;

   always_comb begin
      credit_used = {1'b0, buf_level} + {{LVL_W{1'b0}}, inflight_q};
      fifo_pop    = ~rst & ~flush & ~fifo_empty & (credit_used < CREDITS);
      // The FIFO favours an accepted push, silently dropping a coincident pop.
      pop_acc     = fifo_pop & ~(fifo_push & ~fifo_full);
      inflight_d  = pop_acc;
      fire        = m_valid & m_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) inflight_q <= 1'b0;
      else     inflight_q <= inflight_d;
   end

   // fifo_dout is valid the cycle after an accepted pop; flush discards it.
   stream_buf3 #(.WIDTH(WIDTH)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .wr_en    (inflight_q),
      .wr_data  (fifo_dout),
      .rd_en    (fire),
      .head_data(buf_head),
      .level    (buf_level)
   );

   assign m_valid = (buf_level != '0);
   assign m_data  = buf_head;
   assign level   = buf_level;
endmodule
